// File: rtl/hci_mem_bank_responder_if.sv
// Bank-side channel of the HCI memory interface.
// The interconnect drives the request fields and the bank drives grant and response.
interface hci_mem_bank_responder_if #(
  parameter int unsigned AWM = 12,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = 8,
  parameter int unsigned IW  = 20
) ();
  logic                 req_i;
  logic [AWM-1:0]       add_i;
  logic                 wen_i;
  logic [DW-1:0]        data_i;
  logic [DW/BW-1:0]     be_i;
  logic [IW-1:0]        id_i;
  logic                 ts_i;
  logic                 gnt_o;
  logic                 r_valid_o;
  logic [DW-1:0]        r_data_o;
  logic [IW-1:0]        r_id_o;

  modport master (
    output req_i, add_i, wen_i, data_i, be_i, id_i, ts_i,
    input  gnt_o, r_valid_o, r_data_o, r_id_o
  );

  modport slave (
    input  req_i, add_i, wen_i, data_i, be_i, id_i, ts_i,
    output gnt_o, r_valid_o, r_data_o, r_id_o
  );
endinterface

// File: rtl/hci_mem_bank_responder.sv
// Single-port TCDM bank with post-grant stall, byte-enabled write, read and test-and-set.
// Storage is split into byte lanes, and the response is registered one cycle after the grant.
module hci_mem_bank_lane #(
  parameter int unsigned BW   = 8,
  parameter int unsigned NW   = 1024,
  parameter int unsigned IDXW = 10
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IDXW-1:0] idx_i,
  input  logic [BW-1:0]   wdata_i,
  output logic [BW-1:0]   rdata_o
);
  // No reset, so contents survive rst_ni.
  logic [BW-1:0] mem [NW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdata_i;
  end

  assign rdata_o = mem[idx_i];
endmodule

module hci_mem_bank_responder #(
  parameter int unsigned AWM = 12,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = 8,
  parameter int unsigned IW  = 20,
  parameter int unsigned NW  = 2**(AWM-2),
  parameter int unsigned SW  = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [SW-1:0] stall_i,
  hci_mem_bank_responder_if.slave bus
);
  localparam int unsigned NL   = DW/BW;
  localparam int unsigned IDXW = (NW > 1) ? $clog2(NW) : 1;

  logic [SW-1:0]              stall_q;
  logic                       gnt, exec, ts_op;
  logic [31:0]                word_ext;
  logic [IDXW-1:0]            idx;
  logic [NL-1:0][BW-1:0]      rd_word;
  logic                       r_valid_q;
  logic [DW-1:0]              r_data_q;
  logic [IW-1:0]              r_id_q;
  logic                       unused_addr;

  assign unused_addr = ^bus.add_i[1:0];

  // Word index wraps modulo NW when the bank is smaller than the address space.
  assign word_ext = 32'(bus.add_i[AWM-1:2]);
  assign idx      = IDXW'(word_ext % NW);

  assign gnt   = bus.req_i & (stall_q == '0);
  assign exec  = bus.req_i & gnt;
  assign ts_op = bus.wen_i & bus.ts_i;

  // Test-and-set writes all ones to every lane. A plain write touches only the enabled lanes.
  for (genvar k = 0; k < NL; k++) begin : g_lane
    logic          lane_we;
    logic [BW-1:0] lane_wdata;
    assign lane_we    = exec & (ts_op | (~bus.wen_i & bus.be_i[k]));
    assign lane_wdata = ts_op ? {BW{1'b1}} : bus.data_i[k*BW +: BW];
    hci_mem_bank_lane #(.BW(BW), .NW(NW), .IDXW(IDXW)) u_lane (
      .clk_i   (clk_i),
      .we_i    (lane_we),
      .idx_i   (idx),
      .wdata_i (lane_wdata),
      .rdata_o (rd_word[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (exec) begin
      stall_q <= stall_i;
    end else if (stall_q != '0) begin
      stall_q <= stall_q - 1'b1;
    end
  end

  // rd_word is the pre-edge value, so test-and-set returns the old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
    end else begin
      r_valid_q <= exec;
      if (exec)               r_id_q   <= bus.id_i;
      if (exec && bus.wen_i)  r_data_q <= rd_word;
    end
  end

  assign bus.gnt_o     = gnt;
  assign bus.r_valid_o = r_valid_q;
  assign bus.r_data_o  = r_data_q;
  assign bus.r_id_o    = r_id_q;
endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// Directed bench for hci_mem_bank_responder: reset, byte enables, test-and-set, stall, back-to-back, and reset mid-stream.
module tb_hci_mem_bank_responder;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] stall_i = '0;
  int         n_cmp = 0;
  int         n_err = 0;

  hci_mem_bank_responder_if #(.AWM(12), .DW(32), .BW(8), .IW(20)) bus ();

  hci_mem_bank_responder #(.AWM(12), .DW(32), .BW(8), .IW(20), .SW(4)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (stall_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic wen, input logic ts, input logic [11:0] add,
                       input logic [31:0] data, input logic [3:0] be, input logic [19:0] id);
    bus.wen_i  = wen;
    bus.ts_i   = ts;
    bus.add_i  = add;
    bus.data_i = data;
    bus.be_i   = be;
    bus.id_i   = id;
    bus.req_i  = 1'b1;
  endtask

  // Issue one request, wait for its grant with a bounded wait, and return in the response cycle.
  task automatic do_req(input logic wen, input logic ts, input logic [11:0] add,
                        input logic [31:0] data, input logic [3:0] be, input logic [19:0] id);
    int n = 0;
    drive(wen, ts, add, data, be, id);
    while (bus.gnt_o !== 1'b1 && n < 32) begin
      step();
      n++;
    end
    n_cmp++;
    if (bus.gnt_o !== 1'b1) begin
      n_err++;
      $display("FAIL gnt_wait id=%0d: gnt=%b required 1", id, bus.gnt_o);
    end
    step();
    bus.req_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_i = 1'b0; bus.wen_i = 1'b1; bus.ts_i = 1'b0; bus.add_i = '0;
    bus.data_i = '0; bus.be_i = '0; bus.id_i = '0;
    #12;
    n_cmp++; if (bus.r_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b req 0", bus.r_valid_o); end
    n_cmp++; if (bus.r_data_o !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h req 0", bus.r_data_o); end
    n_cmp++; if (bus.r_id_o !== 20'h0) begin n_err++; $display("FAIL rst_id: got %h req 0", bus.r_id_o); end
    bus.req_i = 1'b1;
    #1;
    n_cmp++; if (bus.gnt_o !== 1'b1) begin n_err++; $display("FAIL rst_gnt_follows_req: got %b req 1", bus.gnt_o); end
    bus.req_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    bus.req_i = 1'b1;
    #1;
    n_cmp++; if (bus.gnt_o !== 1'b1) begin n_err++; $display("FAIL first_cycle_gnt: got %b req 1", bus.gnt_o); end
    bus.req_i = 1'b0;
    #1;
    n_cmp++; if (bus.gnt_o !== 1'b0) begin n_err++; $display("FAIL gnt_no_req: got %b req 0", bus.gnt_o); end
    step();
  endtask

  task automatic test_write_be();
    do_req(1'b0, 1'b0, 12'h010, 32'hDEADBEEF, 4'hF, 20'd5);
    n_cmp++; if (bus.r_valid_o !== 1'b1) begin n_err++; $display("FAIL be_w1_valid: got %b req 1", bus.r_valid_o); end
    n_cmp++; if (bus.r_id_o !== 20'd5) begin n_err++; $display("FAIL be_w1_id: got %0d req 5", bus.r_id_o); end
    do_req(1'b0, 1'b0, 12'h010, 32'h11223344, 4'b0101, 20'd6);
    n_cmp++; if (bus.r_valid_o !== 1'b1) begin n_err++; $display("FAIL be_w2_valid: got %b req 1", bus.r_valid_o); end
    n_cmp++; if (bus.r_id_o !== 20'd6) begin n_err++; $display("FAIL be_w2_id: got %0d req 6", bus.r_id_o); end
    n_cmp++; if (bus.r_data_o !== 32'h0) begin n_err++; $display("FAIL be_write_holds_data: got %h req 00000000", bus.r_data_o); end
    do_req(1'b1, 1'b0, 12'h010, 32'h0, 4'h0, 20'd7);
    n_cmp++; if (bus.r_valid_o !== 1'b1) begin n_err++; $display("FAIL be_rd_valid: got %b req 1", bus.r_valid_o); end
    n_cmp++; if (bus.r_id_o !== 20'd7) begin n_err++; $display("FAIL be_rd_id: got %0d req 7", bus.r_id_o); end
    n_cmp++; if (bus.r_data_o !== 32'hDE22BE44) begin n_err++; $display("FAIL be_rd_data: got %h req de22be44", bus.r_data_o); end
    step();
    n_cmp++; if (bus.r_valid_o !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b req 0", bus.r_valid_o); end
    n_cmp++; if (bus.r_id_o !== 20'd7) begin n_err++; $display("FAIL idle_id_hold: got %0d req 7", bus.r_id_o); end
  endtask

  task automatic test_ts();
    do_req(1'b0, 1'b1, 12'h020, 32'h00000007, 4'hF, 20'd8);
    do_req(1'b1, 1'b1, 12'h020, 32'h0, 4'h0, 20'd9);
    n_cmp++; if (bus.r_data_o !== 32'h00000007) begin n_err++; $display("FAIL ts_old_value: got %h req 00000007", bus.r_data_o); end
    n_cmp++; if (bus.r_id_o !== 20'd9) begin n_err++; $display("FAIL ts_id: got %0d req 9", bus.r_id_o); end
    do_req(1'b1, 1'b0, 12'h020, 32'h0, 4'h0, 20'd10);
    n_cmp++; if (bus.r_data_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL ts_set_value: got %h req ffffffff", bus.r_data_o); end
  endtask

  task automatic test_stall();
    int gnts = 0;
    int vlds = 0;
    logic exp_g, exp_v;
    step();
    stall_i = 4'd3;
    drive(1'b1, 1'b0, 12'h020, 32'h0, 4'h0, 20'd11);
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_g = (c == 0) || (c == 4) || (c == 8);
      exp_v = (c == 1) || (c == 5) || (c == 9);
      n_cmp++; if (bus.gnt_o !== exp_g) begin n_err++; $display("FAIL stall_gnt c=%0d: got %b req %b", c, bus.gnt_o, exp_g); end
      n_cmp++; if (bus.r_valid_o !== exp_v) begin n_err++; $display("FAIL stall_valid c=%0d: got %b req %b", c, bus.r_valid_o, exp_v); end
      if (bus.gnt_o === 1'b1) gnts++;
      if (bus.r_valid_o === 1'b1) vlds++;
      @(posedge clk_i);
    end
    #1;
    bus.req_i = 1'b0;
    stall_i = 4'd0;
    n_cmp++; if (gnts != 3) begin n_err++; $display("FAIL stall_gnt_count: got %0d req 3", gnts); end
    n_cmp++; if (vlds != 3) begin n_err++; $display("FAIL stall_valid_count: got %0d req 3", vlds); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat [2];
    pat[0] = 32'hA5A5A5A5;
    pat[1] = 32'h5A5A5A5A;
    step();
    for (int p = 0; p < 2; p++) begin
      drive(1'b0, 1'b0, 12'h030, pat[p], 4'hF, 20'(20 + 2*p));
      #1;
      n_cmp++; if (bus.gnt_o !== 1'b1) begin n_err++; $display("FAIL b2b_w_gnt p=%0d: got %b req 1", p, bus.gnt_o); end
      step();
      n_cmp++; if (bus.r_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_w_valid p=%0d: got %b req 1", p, bus.r_valid_o); end
      drive(1'b1, 1'b0, 12'h030, 32'h0, 4'h0, 20'(21 + 2*p));
      #1;
      n_cmp++; if (bus.gnt_o !== 1'b1) begin n_err++; $display("FAIL b2b_r_gnt p=%0d: got %b req 1", p, bus.gnt_o); end
      step();
      n_cmp++; if (bus.r_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_r_valid p=%0d: got %b req 1", p, bus.r_valid_o); end
      n_cmp++; if (bus.r_data_o !== pat[p]) begin n_err++; $display("FAIL b2b_r_data p=%0d: got %h req %h", p, bus.r_data_o, pat[p]); end
    end
    bus.req_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    stall_i = 4'd5;
    drive(1'b1, 1'b0, 12'h020, 32'h0, 4'h0, 20'd30);
    step();
    bus.req_i = 1'b0;
    stall_i = 4'd0;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (bus.r_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b req 0", bus.r_valid_o); end
    n_cmp++; if (bus.r_data_o !== 32'h0) begin n_err++; $display("FAIL mid_rst_data: got %h req 00000000", bus.r_data_o); end
    step();
    rst_ni = 1'b1;
    drive(1'b1, 1'b0, 12'h010, 32'h0, 4'h0, 20'd31);
    #1;
    n_cmp++; if (bus.gnt_o !== 1'b1) begin n_err++; $display("FAIL mid_rst_gnt: got %b req 1", bus.gnt_o); end
    step();
    bus.req_i = 1'b0;
    n_cmp++; if (bus.r_valid_o !== 1'b1) begin n_err++; $display("FAIL mid_rst_rd_valid: got %b req 1", bus.r_valid_o); end
    n_cmp++; if (bus.r_data_o !== 32'hDE22BE44) begin n_err++; $display("FAIL mid_rst_retained: got %h req de22be44", bus.r_data_o); end
    n_cmp++; if (bus.r_id_o !== 20'd31) begin n_err++; $display("FAIL mid_rst_id: got %0d req 31", bus.r_id_o); end
  endtask

  initial begin
    test_reset();
    test_write_be();
    test_ts();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
